// File: rtl/dmem_port_arbiter_if.sv
// Request/response bundle between the cpu load/store path, the debug loader port and the data memory.
// The slave modport is the arbiter's view; the master modport is the requesters' and memory's view.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              stall_cpu;

  logic              dbg_req;
  logic              dbg_we;
  logic              dbg_lock;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              misalign;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, stall_cpu,
    input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, misalign,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, stall_cpu,
    output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, misalign,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between cpu (fixed priority) and debug port; grant is combinational, read data returns one cycle later.
// Backpressure: a denied cpu request raises stall_cpu; debug starvation is bounded by MAX_WAIT, and dbg_lock holds ownership for bursts.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input logic               clk,
  input logic               rst_n,
  dmem_port_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU      = 2'd1,
    DBG_LOCK = 2'd2
  } owner_e;

  owner_e            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic              locked;
  logic              force_dbg;
  logic              cpu_win;
  logic              dbg_win;
  logic              rd_cpu_q;
  logic              rd_dbg_q;
  logic              cpu_rv;
  logic              dbg_rv;
  logic [DATA_W-1:0] cpu_hold;
  logic [DATA_W-1:0] dbg_hold;
  logic [ADDR_W-1:0] sel_addr;

  always_comb begin
    locked    = (state == DBG_LOCK) && bus.dbg_lock;
    force_dbg = bus.dbg_req && (wait_cnt == CNT_W'(MAX_WAIT));
    cpu_win   = 1'b0;
    dbg_win   = 1'b0;
    if (rst_n) begin
      if (locked) begin
        dbg_win = bus.dbg_req;
      end else begin
        cpu_win = bus.cpu_req && !force_dbg;
        dbg_win = bus.dbg_req && !cpu_win;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      rd_cpu_q <= 1'b0;
      rd_dbg_q <= 1'b0;
      cpu_hold <= '0;
      dbg_hold <= '0;
    end else begin
      // Dropping dbg_lock releases ownership immediately; that cycle arbitrates as IDLE.
      if (bus.dbg_lock && (dbg_win || state == DBG_LOCK)) begin
        state <= DBG_LOCK;
      end else if (cpu_win) begin
        state <= CPU;
      end else begin
        state <= IDLE;
      end

      if (!bus.dbg_req || dbg_win) begin
        wait_cnt <= '0;
      end else if (wait_cnt < CNT_W'(MAX_WAIT)) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end

      rd_cpu_q <= cpu_win && !bus.cpu_we;
      rd_dbg_q <= dbg_win && !bus.dbg_we;

      if (cpu_rv) begin
        cpu_hold <= bus.mem_rdata;
      end
      if (dbg_rv) begin
        dbg_hold <= bus.mem_rdata;
      end
    end
  end

  // A response pending across a reset edge must never reach the requester.
  assign cpu_rv = rd_cpu_q && rst_n;
  assign dbg_rv = rd_dbg_q && rst_n;

  assign sel_addr       = cpu_win ? bus.cpu_addr : bus.dbg_addr;

  assign bus.cpu_gnt    = cpu_win;
  assign bus.dbg_gnt    = dbg_win;
  assign bus.stall_cpu  = rst_n && bus.cpu_req && !cpu_win;

  assign bus.mem_en     = cpu_win || dbg_win;
  assign bus.mem_we     = cpu_win ? bus.cpu_we : (dbg_win && bus.dbg_we);
  assign bus.mem_addr   = {sel_addr[ADDR_W-1:2], 2'b00};
  assign bus.mem_wdata  = cpu_win ? bus.cpu_wdata : bus.dbg_wdata;
  assign bus.misalign   = (cpu_win && (bus.cpu_addr[1:0] != 2'b00)) ||
                          (dbg_win && (bus.dbg_addr[1:0] != 2'b00));

  assign bus.cpu_rvalid = cpu_rv;
  assign bus.cpu_rdata  = cpu_rv ? bus.mem_rdata : cpu_hold;
  assign bus.dbg_rvalid = dbg_rv;
  assign bus.dbg_rdata  = dbg_rv ? bus.mem_rdata : dbg_hold;

  a_one_gnt: assert property (@(posedge clk) !(cpu_win && dbg_win));

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: scripted scenarios plus a read-response scoreboard keyed by due cycle.
module tb_dmem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int          due;
    bit          is_dbg;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [31:0] model [0:63];
  logic [31:0] mem [0:63];
  logic        mem_init = 1'b0;

  always @(posedge clk) cyc++;

  // Memory device: registered read, valid one cycle after the strobe.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE_0000 + i;
      mem_init <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem[bus.mem_addr[7:2]];
    end
  end

  logic        ec, ed;
  logic [31:0] edat;
  always @(negedge clk) begin
    if (mon_en) begin
      ec = 1'b0; ed = 1'b0; edat = '0;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        if (sbq[0].is_dbg) ed = 1'b1; else ec = 1'b1;
        edat = sbq[0].data;
        void'(sbq.pop_front());
      end
      checks++;
      if (bus.cpu_rvalid !== ec) begin errors++; $display("FAIL cpu_rvalid cyc=%0d: got %b expected %b", cyc, bus.cpu_rvalid, ec); end
      checks++;
      if (bus.dbg_rvalid !== ed) begin errors++; $display("FAIL dbg_rvalid cyc=%0d: got %b expected %b", cyc, bus.dbg_rvalid, ed); end
      if (ec) begin
        checks++;
        if (bus.cpu_rdata !== edat) begin errors++; $display("FAIL cpu_rdata cyc=%0d: got %h expected %h", cyc, bus.cpu_rdata, edat); end
      end
      if (ed) begin
        checks++;
        if (bus.dbg_rdata !== edat) begin errors++; $display("FAIL dbg_rdata cyc=%0d: got %h expected %h", cyc, bus.dbg_rdata, edat); end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_lock = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
  endtask

  task automatic drive_cpu(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
  endtask

  task automatic drive_dbg(input logic we, input logic lock, input logic [31:0] addr, input logic [31:0] wdata);
    bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_lock = lock; bus.dbg_addr = addr; bus.dbg_wdata = wdata;
  endtask

  task automatic push(input bit is_dbg, input logic [31:0] data);
    exp_t e;
    e.due = cyc + 1; e.is_dbg = is_dbg; e.data = data;
    sbq.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (3) tick();
    drive_cpu(1'b0, 32'h4, '0);
    drive_dbg(1'b0, 1'b0, 32'h10, '0);
    @(negedge clk);
    checks++; if (bus.cpu_gnt !== 1'b0)   begin errors++; $display("FAIL rst_cpu_gnt: got %b expected 0", bus.cpu_gnt); end
    checks++; if (bus.dbg_gnt !== 1'b0)   begin errors++; $display("FAIL rst_dbg_gnt: got %b expected 0", bus.dbg_gnt); end
    checks++; if (bus.mem_en !== 1'b0)    begin errors++; $display("FAIL rst_mem_en: got %b expected 0", bus.mem_en); end
    checks++; if (bus.stall_cpu !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", bus.stall_cpu); end
    tick();
    rst_n = 1'b1;
    drive_idle();
    @(negedge clk);
    checks++; if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rst_cpu_rvalid: got %b expected 0", bus.cpu_rvalid); end
    checks++; if (bus.dbg_rvalid !== 1'b0) begin errors++; $display("FAIL rst_dbg_rvalid: got %b expected 0", bus.dbg_rvalid); end
    checks++; if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_cpu_rdata: got %h expected 0", bus.cpu_rdata); end
    checks++; if (bus.dbg_rdata !== 32'h0) begin errors++; $display("FAIL rst_dbg_rdata: got %h expected 0", bus.dbg_rdata); end
    mon_en = 1'b1;
  endtask

  task automatic test_cpu_load();
    tick(); drive_idle(); drive_cpu(1'b0, 32'h8, '0);
    @(negedge clk);
    checks++; if (bus.cpu_gnt !== 1'b1)      begin errors++; $display("FAIL ld_gnt: got %b expected 1", bus.cpu_gnt); end
    checks++; if (bus.mem_en !== 1'b1)       begin errors++; $display("FAIL ld_mem_en: got %b expected 1", bus.mem_en); end
    checks++; if (bus.mem_we !== 1'b0)       begin errors++; $display("FAIL ld_mem_we: got %b expected 0", bus.mem_we); end
    checks++; if (bus.mem_addr !== 32'h8)    begin errors++; $display("FAIL ld_mem_addr: got %h expected 8", bus.mem_addr); end
    checks++; if (bus.stall_cpu !== 1'b0)    begin errors++; $display("FAIL ld_stall: got %b expected 0", bus.stall_cpu); end
    checks++; if (bus.misalign !== 1'b0)     begin errors++; $display("FAIL ld_misalign: got %b expected 0", bus.misalign); end
    push(1'b0, model[2]);
    tick(); drive_cpu(1'b1, 32'h20, 32'h1234_5678);
    @(negedge clk);
    checks++; if (bus.mem_we !== 1'b1)              begin errors++; $display("FAIL st_mem_we: got %b expected 1", bus.mem_we); end
    checks++; if (bus.mem_wdata !== 32'h1234_5678)  begin errors++; $display("FAIL st_mem_wdata: got %h expected 12345678", bus.mem_wdata); end
    checks++; if (bus.mem_addr !== 32'h20)          begin errors++; $display("FAIL st_mem_addr: got %h expected 20", bus.mem_addr); end
    model[8] = 32'h1234_5678;
    tick(); drive_cpu(1'b0, 32'h20, '0);
    @(negedge clk);
    push(1'b0, model[8]);
    tick(); drive_idle();
    @(negedge clk);
  endtask

  task automatic test_interleave();
    tick(); drive_idle(); drive_cpu(1'b0, 32'h4, '0);
    @(negedge clk);
    checks++; if (bus.cpu_gnt !== 1'b1) begin errors++; $display("FAIL il_cpu_gnt: got %b expected 1", bus.cpu_gnt); end
    push(1'b0, model[1]);
    tick(); drive_idle(); drive_dbg(1'b0, 1'b0, 32'h10, '0);
    @(negedge clk);
    checks++; if (bus.dbg_gnt !== 1'b1)    begin errors++; $display("FAIL il_dbg_gnt: got %b expected 1", bus.dbg_gnt); end
    checks++; if (bus.mem_addr !== 32'h10) begin errors++; $display("FAIL il_mem_addr: got %h expected 10", bus.mem_addr); end
    checks++; if (bus.dbg_rdata !== 32'h0) begin errors++; $display("FAIL il_dbg_hold: got %h expected 0", bus.dbg_rdata); end
    push(1'b1, model[4]);
    tick(); drive_idle();
    @(negedge clk);
    checks++; if (bus.cpu_rdata !== model[1]) begin errors++; $display("FAIL il_cpu_hold: got %h expected %h", bus.cpu_rdata, model[1]); end
    tick();
    @(negedge clk);
    checks++; if (bus.dbg_rdata !== model[4]) begin errors++; $display("FAIL il_dbg_keep: got %h expected %h", bus.dbg_rdata, model[4]); end
  endtask

  task automatic test_misalign();
    tick(); drive_idle(); drive_dbg(1'b0, 1'b0, 32'h13, '0);
    @(negedge clk);
    checks++; if (bus.mem_addr !== 32'h10) begin errors++; $display("FAIL ma_mem_addr: got %h expected 10", bus.mem_addr); end
    checks++; if (bus.misalign !== 1'b1)   begin errors++; $display("FAIL ma_pulse: got %b expected 1", bus.misalign); end
    push(1'b1, model[4]);
    tick(); drive_idle();
    @(negedge clk);
    checks++; if (bus.misalign !== 1'b0)   begin errors++; $display("FAIL ma_clear: got %b expected 0", bus.misalign); end
    tick(); drive_cpu(1'b1, 32'h22, 32'hDEAD_BEEF);
    @(negedge clk);
    checks++; if (bus.mem_addr !== 32'h20) begin errors++; $display("FAIL ma_st_addr: got %h expected 20", bus.mem_addr); end
    checks++; if (bus.misalign !== 1'b1)   begin errors++; $display("FAIL ma_st_pulse: got %b expected 1", bus.misalign); end
    model[8] = 32'hDEAD_BEEF;
    tick(); drive_cpu(1'b0, 32'h20, '0);
    @(negedge clk);
    checks++; if (bus.misalign !== 1'b0)   begin errors++; $display("FAIL ma_aligned: got %b expected 0", bus.misalign); end
    push(1'b0, model[8]);
    tick(); drive_idle();
    @(negedge clk);
  endtask

  task automatic test_starvation();
    bit exp_d;
    for (int i = 0; i < 10; i++) begin
      tick(); drive_cpu(1'b0, 32'h4, '0); drive_dbg(1'b0, 1'b0, 32'h10, '0);
      @(negedge clk);
      exp_d = ((i % 5) == 4);
      checks++; if (bus.cpu_gnt !== !exp_d)  begin errors++; $display("FAIL sv_cpu_gnt[%0d]: got %b expected %b", i, bus.cpu_gnt, !exp_d); end
      checks++; if (bus.dbg_gnt !== exp_d)   begin errors++; $display("FAIL sv_dbg_gnt[%0d]: got %b expected %b", i, bus.dbg_gnt, exp_d); end
      checks++; if (bus.stall_cpu !== exp_d) begin errors++; $display("FAIL sv_stall[%0d]: got %b expected %b", i, bus.stall_cpu, exp_d); end
      if (exp_d) push(1'b1, model[4]); else push(1'b0, model[1]);
    end
    tick(); drive_idle();
    @(negedge clk);
  endtask

  task automatic test_lock();
    for (int i = 0; i < 12; i++) begin
      tick(); drive_idle();
      drive_dbg(1'b1, 1'b1, 32'(4 * i), 32'(i));
      if (i > 0) drive_cpu(1'b0, 32'h0, '0);
      @(negedge clk);
      checks++; if (bus.dbg_gnt !== 1'b1)         begin errors++; $display("FAIL lk_dbg_gnt[%0d]: got %b expected 1", i, bus.dbg_gnt); end
      checks++; if (bus.cpu_gnt !== 1'b0)         begin errors++; $display("FAIL lk_cpu_gnt[%0d]: got %b expected 0", i, bus.cpu_gnt); end
      checks++; if (bus.stall_cpu !== (i > 0))    begin errors++; $display("FAIL lk_stall[%0d]: got %b expected %b", i, bus.stall_cpu, (i > 0)); end
      checks++; if (bus.mem_addr !== 32'(4 * i))  begin errors++; $display("FAIL lk_addr[%0d]: got %h expected %h", i, bus.mem_addr, 32'(4 * i)); end
      checks++; if (bus.mem_wdata !== 32'(i))     begin errors++; $display("FAIL lk_wdata[%0d]: got %h expected %h", i, bus.mem_wdata, 32'(i)); end
      model[i] = 32'(i);
    end
    tick(); drive_idle(); drive_cpu(1'b0, 32'h0, '0);
    @(negedge clk);
    checks++; if (bus.cpu_gnt !== 1'b1)   begin errors++; $display("FAIL lk_release_gnt: got %b expected 1", bus.cpu_gnt); end
    checks++; if (bus.stall_cpu !== 1'b0) begin errors++; $display("FAIL lk_release_stall: got %b expected 0", bus.stall_cpu); end
    push(1'b0, model[0]);
    tick(); drive_idle(); drive_dbg(1'b0, 1'b0, 32'h2C, '0);
    @(negedge clk);
    push(1'b1, model[11]);
    tick(); drive_idle();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit exp_d;
    for (int i = 0; i < 3; i++) begin
      tick(); drive_cpu(1'b0, 32'h4, '0); drive_dbg(1'b0, 1'b0, 32'h10, '0);
      @(negedge clk);
      checks++; if (bus.cpu_gnt !== 1'b1) begin errors++; $display("FAIL rm_pre_gnt[%0d]: got %b expected 1", i, bus.cpu_gnt); end
      if (i < 2) push(1'b0, model[1]);
    end
    tick(); rst_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rm_rvalid: got %b expected 0", bus.cpu_rvalid); end
    checks++; if (bus.mem_en !== 1'b0)     begin errors++; $display("FAIL rm_mem_en: got %b expected 0", bus.mem_en); end
    checks++; if (bus.stall_cpu !== 1'b0)  begin errors++; $display("FAIL rm_stall: got %b expected 0", bus.stall_cpu); end
    for (int i = 0; i < 5; i++) begin
      tick(); rst_n = 1'b1;
      @(negedge clk);
      if (i == 0) begin
        checks++; if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL rm_cpu_rdata: got %h expected 0", bus.cpu_rdata); end
      end
      exp_d = (i == 4);
      checks++; if (bus.dbg_gnt !== exp_d) begin errors++; $display("FAIL rm_wait[%0d]: got %b expected %b", i, bus.dbg_gnt, exp_d); end
      if (exp_d) push(1'b1, model[4]); else push(1'b0, model[1]);
    end
    tick(); drive_idle(); drive_dbg(1'b1, 1'b1, 32'h30, 32'h77);
    @(negedge clk);
    checks++; if (bus.dbg_gnt !== 1'b1) begin errors++; $display("FAIL rm_lock_gnt: got %b expected 1", bus.dbg_gnt); end
    model[12] = 32'h77;
    tick(); rst_n = 1'b0; bus.dbg_req = 1'b0;
    @(negedge clk);
    tick(); rst_n = 1'b1; drive_cpu(1'b0, 32'h4, '0);
    @(negedge clk);
    checks++; if (bus.cpu_gnt !== 1'b1) begin errors++; $display("FAIL rm_unlock_gnt: got %b expected 1", bus.cpu_gnt); end
    push(1'b0, model[1]);
    tick(); drive_idle(); drive_dbg(1'b0, 1'b0, 32'h30, '0);
    @(negedge clk);
    push(1'b1, model[12]);
    repeat (2) begin tick(); drive_idle(); @(negedge clk); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) model[i] = 32'hC0DE_0000 + i;
    test_reset();
    test_cpu_load();
    test_interleave();
    test_misalign();
    test_starvation();
    test_lock();
    test_reset_mid();
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending expected 0", sbq.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
